// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl
//   Frames a streaming complex sample input into 8-point blocks for an
//   external dit_fft_8 datapath. It waits a fixed datapath latency, captures
//   the result, and streams the 8 result bins out with a valid/ready
//   handshake. Frames never overlap: FILL -> WAIT -> DRAIN -> FILL.
//
// Ports
//   clk, reset                 clock; asynchronous active-low reset
//   in_valid/in_ready          input sample handshake (ready only in FILL)
//   in_re, in_im, in_mode      sample data; mode (0 FFT, 1 IFFT) taken from
//                              the first sample of each frame
//   fft_x, fft_mode            8 packed input samples and mode to datapath
//   fft_y                      packed datapath result (same packing as fft_x)
//   out_valid/out_ready        result sample handshake
//   out_re, out_im, out_idx    result sample and its bin index
//   out_last                   high with bin 7
//   frame_done                 pulse on the final output handshake
//   frame_cnt                  completed frames, modulo 256
//
// Packing: sample i re at [2W*i+W-1:2W*i], im at [2W*i+2W-1:2W*i+W].
module fft_frame_ctrl #(
    parameter int W       = 16,
    parameter int FFT_LAT = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] in_re,
    input  logic signed [W-1:0] in_im,
    input  logic                in_mode,
    output logic [16*W-1:0]     fft_x,
    output logic                fft_mode,
    input  logic [16*W-1:0]     fft_y,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] out_re,
    output logic signed [W-1:0] out_im,
    output logic [2:0]          out_idx,
    output logic                out_last,
    output logic                frame_done,
    output logic [7:0]          frame_cnt
);

    localparam int LW = (FFT_LAT > 1) ? $clog2(FFT_LAT) : 1;

    typedef enum logic [1:0] {FILL, WAIT, DRAIN} state_e;

    state_e         state_q,     state_d;
    logic [2*W-1:0] in_buf_q  [8];
    logic [2*W-1:0] in_buf_d  [8];
    logic [2*W-1:0] out_buf_q [8];
    logic [2*W-1:0] out_buf_d [8];
    logic [2:0]     wr_idx_q,    wr_idx_d;
    logic [2:0]     rd_idx_q,    rd_idx_d;
    logic [LW-1:0]  lat_cnt_q,   lat_cnt_d;
    logic           fft_mode_q,  fft_mode_d;
    logic [7:0]     frame_cnt_q, frame_cnt_d;
    logic           in_ready_q,  in_ready_d;
    logic           out_valid_q, out_valid_d;

    logic in_acc;
    logic out_hs;

    assign in_acc = in_ready_q && in_valid;
    assign out_hs = out_valid_q && out_ready;

    always_comb begin
        // NOTE: every _d starts as its _q so no path leaves a variable
        // unassigned; without this default the tool would infer latches.
        state_d     = state_q;
        in_buf_d    = in_buf_q;
        out_buf_d   = out_buf_q;
        wr_idx_d    = wr_idx_q;
        rd_idx_d    = rd_idx_q;
        lat_cnt_d   = lat_cnt_q;
        fft_mode_d  = fft_mode_q;
        frame_cnt_d = frame_cnt_q;

        unique case (state_q)
            FILL: begin
                if (in_acc) begin
                    in_buf_d[wr_idx_q] = {in_im, in_re};
                    if (wr_idx_q == 3'd0) begin
                        fft_mode_d = in_mode;
                    end
                    // 3-bit index wraps 7 -> 0 on its own.
                    wr_idx_d = wr_idx_q + 3'd1;
                    if (wr_idx_q == 3'd7) begin
                        state_d   = WAIT;
                        lat_cnt_d = '0;
                    end
                end
            end
            WAIT: begin
                lat_cnt_d = lat_cnt_q + LW'(1);
                if (lat_cnt_q == LW'(FFT_LAT - 1)) begin
                    for (int i = 0; i < 8; i++) begin
                        out_buf_d[i] = fft_y[2*W*i +: 2*W];
                    end
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (out_hs) begin
                    rd_idx_d = rd_idx_q + 3'd1;
                    if (rd_idx_q == 3'd7) begin
                        frame_cnt_d = frame_cnt_q + 8'd1;
                        state_d     = FILL;
                    end
                end
            end
            default: state_d = FILL;
        endcase

        // Ready follows the state one edge later, so a frame that just
        // drained cannot be overlapped by an accept on the same edge.
        in_ready_d = (state_d == FILL);
        // Valid rises one cycle after entering DRAIN, giving the first
        // result FFT_LAT+1 cycles after the eighth input handshake.
        out_valid_d = (state_q == DRAIN) && (state_d == DRAIN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= FILL;
            // NOTE: the sample buffers are reset too, because fft_x and the
            // result outputs must read as zero while reset is held.
            in_buf_q    <= '{default: '0};
            out_buf_q   <= '{default: '0};
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            lat_cnt_q   <= '0;
            fft_mode_q  <= 1'b0;
            frame_cnt_q <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop reading the
            // pre-edge value of the others, whatever the statement order.
            state_q     <= state_d;
            in_buf_q    <= in_buf_d;
            out_buf_q   <= out_buf_d;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            lat_cnt_q   <= lat_cnt_d;
            fft_mode_q  <= fft_mode_d;
            frame_cnt_q <= frame_cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            fft_x[2*W*i +: 2*W] = in_buf_q[i];
        end
    end

    assign in_ready   = in_ready_q;
    assign fft_mode   = fft_mode_q;
    assign out_valid  = out_valid_q;
    assign out_re     = out_buf_q[rd_idx_q][W-1:0];
    assign out_im     = out_buf_q[rd_idx_q][2*W-1:W];
    assign out_idx    = rd_idx_q;
    assign out_last   = out_valid_q && (rd_idx_q == 3'd7);
    assign frame_done = out_hs && (rd_idx_q == 3'd7);
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Testbench for fft_frame_ctrl. A stub datapath produces fft_y from fft_x.
// The reference model collects accepted samples per frame and, when a frame
// completes, pushes the 8 expected result samples into a scoreboard queue.
// An independent monitor pops and compares on every output handshake.
module tb_fft_frame_ctrl;

    localparam int W       = 16;
    localparam int FFT_LAT = 3;
    localparam int SPAN    = 8 + FFT_LAT + 1 + 8;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [W-1:0]    in_re = '0;
    logic [W-1:0]    in_im = '0;
    logic            in_mode = 1'b0;
    logic [16*W-1:0] fft_x;
    logic            fft_mode;
    logic [16*W-1:0] fft_y;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [W-1:0]    out_re;
    logic [W-1:0]    out_im;
    logic [2:0]      out_idx;
    logic            out_last;
    logic            frame_done;
    logic [7:0]      frame_cnt;

    fft_frame_ctrl #(.W(W), .FFT_LAT(FFT_LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .in_mode   (in_mode),
        .fft_x     (fft_x),
        .fft_mode  (fft_mode),
        .fft_y     (fft_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .frame_done(frame_done),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Stub datapath: 0 -> constant re=0x1000/im=0; 1 -> bin k takes sample
    // 7-k with re/im swapped and the imaginary part scrambled by mode.
    logic stub_sel = 1'b0;
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            if (!stub_sel) begin
                fft_y[2*W*k +: 2*W] = {16'h0000, 16'h1000};
            end else begin
                fft_y[2*W*k +: 2*W] = {fft_x[2*W*(7-k) +: W] ^ (fft_mode ? 16'hA5A5 : 16'h0000),
                                       fft_x[2*W*(7-k) + W +: W]};
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [W-1:0]    re;
        logic [W-1:0]    im;
        logic [2:0]      idx;
        logic            last;
        logic [7:0]      cnt;
        logic [16*W-1:0] x;
    } exp_t;

    exp_t         sb_q[$];
    logic [W-1:0] s_re[8];
    logic [W-1:0] s_im[8];
    int           n_acc     = 0;
    logic         cur_mode  = 1'b0;
    logic [7:0]   model_cnt = '0;
    int           acc8_cyc  = 0;
    int           prev_first = 0;
    logic         have_prev = 1'b0;
    logic         b2b_chk   = 1'b0;
    int           n_frames_out = 0;

    // Reference model: frame assembly from observed input handshakes.
    always @(negedge clk) begin
        if (!reset) begin
            n_acc     = 0;
            model_cnt = '0;
            have_prev = 1'b0;
            sb_q.delete();
        end else if (in_valid && in_ready) begin
            if (n_acc == 0) begin
                cur_mode = in_mode;
                if (b2b_chk && have_prev) check("frame_span", 256'(cyc + 1 - prev_first), 256'(SPAN));
                prev_first = cyc + 1;
                have_prev  = 1'b1;
            end else begin
                check("mode_hold", 256'(fft_mode), 256'(cur_mode));
            end
            s_re[n_acc] = in_re;
            s_im[n_acc] = in_im;
            n_acc++;
            if (n_acc == 8) begin
                exp_t e;
                logic [16*W-1:0] px;
                for (int i = 0; i < 8; i++) px[2*W*i +: 2*W] = {s_im[i], s_re[i]};
                for (int k = 0; k < 8; k++) begin
                    e.re   = stub_sel ? s_im[7-k] : 16'h1000;
                    e.im   = stub_sel ? (s_re[7-k] ^ (cur_mode ? 16'hA5A5 : 16'h0000)) : 16'h0000;
                    e.idx  = 3'(k);
                    e.last = (k == 7);
                    e.cnt  = model_cnt;
                    e.x    = px;
                    sb_q.push_back(e);
                end
                model_cnt = model_cnt + 8'd1;
                acc8_cyc  = cyc + 1;
                n_acc     = 0;
            end
        end
    end

    // Monitor: compares every output handshake against the scoreboard.
    logic         prev_valid = 1'b0;
    logic         stalled    = 1'b0;
    logic [W-1:0] h_re, h_im;
    logic [2:0]   h_idx;
    always @(negedge clk) begin
        if (!reset) begin
            prev_valid = 1'b0;
            stalled    = 1'b0;
        end else begin
            if (stalled) begin
                check("stall_valid", 256'(out_valid), 256'(1));
                check("stall_re",    256'(out_re),    256'(h_re));
                check("stall_im",    256'(out_im),    256'(h_im));
                check("stall_idx",   256'(out_idx),   256'(h_idx));
                check("stall_in_ready", 256'(in_ready), 256'(0));
            end
            if (out_valid && !prev_valid) check("first_valid_latency", 256'(cyc - acc8_cyc), 256'(FFT_LAT + 1));
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_output", 256'(1), 256'(0));
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("out_re",     256'(out_re),     256'(e.re));
                    check("out_im",     256'(out_im),     256'(e.im));
                    check("out_idx",    256'(out_idx),    256'(e.idx));
                    check("out_last",   256'(out_last),   256'(e.last));
                    check("frame_done", 256'(frame_done), 256'(e.last));
                    check("frame_cnt",  256'(frame_cnt),  256'(e.cnt));
                    check("drain_in_ready", 256'(in_ready), 256'(0));
                    if (e.idx == 3'd0) check("fft_x", 256'(fft_x), 256'(e.x));
                    if (e.last) n_frames_out++;
                end
            end
            stalled    = out_valid && !out_ready;
            h_re       = out_re;
            h_im       = out_im;
            h_idx      = out_idx;
            prev_valid = out_valid;
        end
    end

    // out_ready policy: 0 always ready, 1 random, 2 stall 5 cycles at bin 3.
    int rdy_policy = 0;
    int stall_left = 0;
    logic stall_done = 1'b0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_policy)
                1: out_ready = ($urandom_range(0, 3) != 0);
                2: begin
                    if (stall_left > 0) begin
                        out_ready = 1'b0;
                        stall_left--;
                    end else if (out_valid && out_idx == 3'd3 && !stall_done) begin
                        out_ready  = 1'b0;
                        stall_left = 4;
                        stall_done = 1'b1;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
                default: out_ready = 1'b1;
            endcase
        end
    end

    task automatic send(input logic [W-1:0] re, input logic [W-1:0] im, input logic md, input int max_gap);
        in_valid = 1'b1;
        in_re    = re;
        in_im    = im;
        in_mode  = md;
        for (int n = 0; ; n++) begin
            @(negedge clk);
            if (in_ready) break;
            if (n > 500) begin
                check("send_timeout", 256'(1), 256'(0));
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_re    = W'($urandom);
        in_im    = W'($urandom);
        in_mode  = 1'($urandom);
        repeat ($urandom_range(0, max_gap)) @(posedge clk);
        #1;
    endtask

    task automatic wait_frames(input int target);
        for (int n = 0; n_frames_out < target; n++) begin
            @(posedge clk);
            if (n > 2000) begin
                check("drain_timeout", 256'(n_frames_out), 256'(target));
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_checks();
        check("rst_in_ready",   256'(in_ready),   256'(0));
        check("rst_out_valid",  256'(out_valid),  256'(0));
        check("rst_fft_x",      256'(fft_x),      256'(0));
        check("rst_out_re",     256'(out_re),     256'(0));
        check("rst_out_im",     256'(out_im),     256'(0));
        check("rst_out_idx",    256'(out_idx),    256'(0));
        check("rst_out_last",   256'(out_last),   256'(0));
        check("rst_frame_done", 256'(frame_done), 256'(0));
        check("rst_frame_cnt",  256'(frame_cnt),  256'(0));
        check("rst_fft_mode",   256'(fft_mode),   256'(0));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        #2;
        reset_checks();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        check("in_ready_before_edge", 256'(in_ready), 256'(0));
        @(posedge clk);
        #1;
        check("in_ready_after_edge", 256'(in_ready), 256'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "global timeout");
    end

    initial begin
        int base;
        // Power-on reset.
        repeat (2) @(posedge clk);
        #2;
        reset_checks();
        @(posedge clk);
        #1;
        reset = 1'b1;
        check("in_ready_before_edge", 256'(in_ready), 256'(0));
        @(posedge clk);
        #1;
        check("in_ready_after_edge", 256'(in_ready), 256'(1));

        // Impulse frame against the constant stub.
        rdy_policy = 0;
        stub_sel   = 1'b0;
        for (int i = 0; i < 8; i++) send((i == 0) ? 16'h1000 : 16'h0000, 16'h0000, 1'b0, 0);
        wait_frames(1);
        check("cnt_after_first", 256'(frame_cnt), 256'(1));
        check("mode_fft", 256'(fft_mode), 256'(0));

        // IFFT frame with in_mode toggling after sample 0, random back-pressure.
        stub_sel   = 1'b1;
        rdy_policy = 1;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 8; i++) send(W'($urandom), W'($urandom), (i % 2 == 0), 3);
            wait_frames(2 + f);
            check("mode_ifft_held", 256'(fft_mode), 256'(1));
        end

        // Five-cycle stall at bin 3.
        rdy_policy = 2;
        stall_done = 1'b0;
        for (int i = 0; i < 8; i++) send(W'($urandom), W'($urandom), 1'($urandom), 2);
        wait_frames(4);
        check("stall_applied", 256'(stall_done), 256'(1));

        // Reset after 5 accepts discards the partial frame.
        rdy_policy = 1;
        for (int i = 0; i < 5; i++) send(W'($urandom), W'($urandom), 1'b1, 1);
        do_reset();
        check("partial_dropped", 256'(sb_q.size()), 256'(0));
        for (int i = 0; i < 8; i++) send(W'($urandom), W'($urandom), 1'($urandom), 1);
        wait_frames(5);
        check("cnt_after_reset", 256'(frame_cnt), 256'(1));

        // 257 back-to-back frames with in_valid held high and changing data.
        do_reset();
        rdy_policy = 0;
        b2b_chk    = 1'b1;
        base       = n_frames_out;
        in_valid   = 1'b1;
        for (int n = 0; n_frames_out < base + 257; n++) begin
            in_re   = W'($urandom);
            in_im   = W'($urandom);
            in_mode = 1'($urandom);
            @(posedge clk);
            #1;
            if (n > 257 * (SPAN + 4)) begin
                check("b2b_timeout", 256'(n_frames_out - base), 256'(257));
                break;
            end
        end
        in_valid = 1'b0;
        b2b_chk  = 1'b0;
        @(posedge clk);
        #1;
        check("cnt_after_257", 256'(frame_cnt), 256'(8'(257)));
        check("b2b_frames", 256'(n_frames_out - base), 256'(257));
        check("scoreboard_empty", 256'(sb_q.size()), 256'(0));
        check("no_stray_accepts", 256'(n_acc), 256'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_frame_ctrl.md
FFT_FRAME_CTRL -- requirements
Module: fft_frame_ctrl

Interface
REQ-001 SHALL have parameter W, default 16, meaning sample component width in Q4.12.
REQ-002 SHALL have parameter FFT_LAT, default 3, meaning clk cycles from fft_x/fft_mode valid to fft_y valid on dit_fft_8.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  upstream sample valid.
REQ-006 in_ready  output  1  block accepts sample this cycle.
REQ-007 in_re, in_im  input  W each  signed sample real and imaginary parts.
REQ-008 in_mode  input  1  0 = FFT, 1 = IFFT; sampled with the first sample of a frame.
REQ-009 fft_x  output  16*W  8 complex samples; sample i re at [2W*i+W-1:2W*i], im at [2W*i+2W-1:2W*i+W].
REQ-010 fft_mode  output  1  mode driven to the datapath.
REQ-011 fft_y  input  16*W  datapath result, same packing as fft_x.
REQ-012 out_valid  output  1  result sample valid.
REQ-013 out_ready  input  1  downstream accepts the result sample.
REQ-014 out_re, out_im  output  W each  result sample.
REQ-015 out_idx  output  3  bin index of the current result sample.
REQ-016 out_last  output  1  high with out_idx == 7.
REQ-017 frame_done  output  1  one-cycle pulse on the last output handshake.
REQ-018 frame_cnt  output  8  completed frames, modulo 256.

Function
REQ-019 SHALL implement FSM states FILL, WAIT, DRAIN; there is no frame overlap.
REQ-020 FILL: in_ready = 1; on each in_valid&&in_ready, store sample at wr_idx and increment wr_idx (3 bits).
REQ-021 On the first accepted sample of a frame (wr_idx == 0), in_mode SHALL be latched into fft_mode, which holds until the next frame's first sample.
REQ-022 On the accept with wr_idx == 7, SHALL go to WAIT, wrap wr_idx to 0, and clear the latency counter.
REQ-023 fft_x SHALL be driven directly from the input buffer registers; the buffer SHALL NOT change outside FILL accepts.
REQ-024 WAIT: in_ready = 0; latency counter increments each cycle; on the cycle the counter equals FFT_LAT-1, fft_y SHALL be captured into the output buffer and the FSM SHALL go to DRAIN.
REQ-025 Consequence: the first out_valid asserts FFT_LAT+1 cycles after the 8th input handshake edge.
REQ-026 DRAIN: out_valid = 1; out_re/out_im/out_idx SHALL come from the output buffer at rd_idx; on out_valid&&out_ready, rd_idx increments.
REQ-027 While out_ready = 0, all outputs SHALL hold stable.
REQ-028 On the handshake with rd_idx == 7: pulse frame_done, increment frame_cnt (255 wraps to 0), reset rd_idx to 0, and return to FILL.
REQ-029 The next FILL accept may occur on the cycle after that return, never on the same cycle.
REQ-030 in_valid while in WAIT or DRAIN SHALL be ignored, with no buffer write.
REQ-031 in_valid low in mid-FILL SHALL stall with no state change; a partial frame persists indefinitely.
REQ-032 No arithmetic on sample data: samples pass bit-exact from in_* to fft_x and from fft_y to out_*.

Reset
REQ-033 While reset = 0, the block SHALL be in state FILL with wr_idx = rd_idx = 0, latency counter = 0, frame_cnt = 0, and fft_mode = 0.
REQ-034 While reset = 0, all buffers SHALL be 0, so fft_x = 0 and out_re = out_im = 0.
REQ-035 While reset = 0, in_ready = 0, out_valid = 0, out_idx = 0, out_last = 0, and frame_done = 0.
REQ-036 in_ready SHALL rise on the first clk edge after reset deasserts.
REQ-037 Reset asserted mid-frame in any state SHALL discard the partial or in-flight frame immediately, with no frame_done pulse.

Verification
REQ-038 Send 8 samples with in_re = 0x1000 for i = 0 and 0 otherwise, in_im = 0, in_mode = 0, with a stub fft_y = 0x1000 on all re and 0 on all im -> fft_x matches the packing, fft_mode = 0, first out_valid FFT_LAT+1 cycles after the 8th accept, 8 outputs of 0x1000, out_idx 0..7, out_last and frame_done at idx 7, frame_cnt = 1.
REQ-039 in_mode = 1 on sample 0, toggled on samples 1..7 -> fft_mode stays 1 throughout the frame.
REQ-040 Drive out_ready = 0 for 5 cycles at idx 3 -> out_re/out_im/out_idx hold, in_ready = 0, and idx 3 is emitted once.
REQ-041 Assert reset after 5 accepts, then send a full 8-sample frame -> only the new frame appears on the output, with frame_cnt = 1.
REQ-042 Hold in_valid high through WAIT/DRAIN with changing data -> the output equals the stubbed fft_y, and the next frame starts only after frame_done.
REQ-043 Run 257 back-to-back frames -> frame_cnt = 1, and each frame spans exactly 8 + FFT_LAT + 1 + 8 cycles when in_valid = out_ready = 1.
